score_keeper: RTL and testbench

- Upstream score source for the two-digit seven-segment scoreboard.
- Consumes per-shot results from the game core: a shot pulse plus a hit/miss flag.
- Tracks whose turn it is and keeps saturating 2-bit hit counts per player; these drive the scoreboard's p1_score/p2_score inputs directly.
- Detects the winning hit, freezes the game and reports the winner until a new game starts.

---
 rtl/score_keeper.sv | 163 ++++++++++++++++
 tb/tb_score_keeper.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/score_keeper.sv
// -----------------------------------------------------------------------------
// score_keeper
//
// Purpose:
//   Upstream score source for the two-digit seven-segment scoreboard.
//
//   The game core reports each shot as a pulse plus a hit/miss flag. This block
//   takes those reports and keeps the game state:
//     - whose turn it is,
//     - a saturating 2-bit hit count per player,
//     - whether the game has been won, and by whom.
//   After the winning hit it freezes the results until a new game starts.
//   After every other accepted shot it enforces a short lockout window, so
//   that a bouncing shot pulse is not counted twice.
//
// Parameters:
//   WIN_SCORE       hit count that ends the game (1..3)
//   LOCKOUT_CYCLES  cycles after an accepted shot during which shots are
//                   ignored; 0 disables the lockout
//
// Optional feature (macro HIT_STREAK_EN):
//   Defined   - a non-winning hit keeps the turn with the shooter;
//               a miss passes the turn.
//   Undefined - every accepted non-winning shot passes the turn.
//
// Ports:
//   clk          in   system clock
//   rst          in   synchronous, active-high reset
//   new_game     in   one-cycle pulse: clear scores, start play
//   shot_valid   in   one-cycle pulse: a shot has resolved
//   shot_hit     in   qualifies shot_valid: 1 = hit, 0 = miss
//   p1_score     out  player 1 hit count (2 bits)
//   p2_score     out  player 2 hit count (2 bits)
//   turn         out  0 = player 1 to shoot, 1 = player 2
//   shot_accept  out  one-cycle pulse when a shot is counted
//   game_over    out  high while the game is won and frozen
//   winner       out  00 none, 01 player 1, 10 player 2
//
// All outputs are registered; there is no combinational input-to-output path.
// -----------------------------------------------------------------------------
module score_keeper #(
    parameter int WIN_SCORE      = 3,
    parameter int LOCKOUT_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       new_game,
    input  logic       shot_valid,
    input  logic       shot_hit,
    output logic [1:0] p1_score,
    output logic [1:0] p2_score,
    output logic       turn,
    output logic       shot_accept,
    output logic       game_over,
    output logic [1:0] winner
);

    // The lockout counter is always at least one bit wide, even when the
    // lockout is disabled.
    localparam int CW = (LOCKOUT_CYCLES < 1) ? 1 : $clog2(LOCKOUT_CYCLES + 1);
    localparam logic [CW-1:0] LOCK_LOAD = CW'(LOCKOUT_CYCLES);
    localparam logic [CW-1:0] LOCK_ONE  = CW'(1);
    localparam logic [1:0]    WIN       = 2'(WIN_SCORE);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PLAY    = 2'd1,
        LOCKOUT = 2'd2,
        OVER    = 2'd3
    } state_t;

    state_t          state_reg;
    logic [CW-1:0]   lock_cnt_reg;

    // Shot evaluation for the player whose turn it is.
    logic [1:0] shooter_score;
    logic [1:0] scored_next;
    logic       wins;
    logic       keep_turn;

    always_comb begin
        shooter_score = turn ? p2_score : p1_score;
        scored_next   = shooter_score;
        // A hit adds one point. The count saturates at 3 and never wraps to 0.
        if (shot_hit && (shooter_score != 2'd3)) begin
            scored_next = shooter_score + 2'd1;
        end
        wins = shot_hit && (scored_next == WIN);
`ifdef HIT_STREAK_EN
        keep_turn = shot_hit;
`else
        keep_turn = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            lock_cnt_reg <= '0;
            p1_score     <= 2'd0;
            p2_score     <= 2'd0;
            turn         <= 1'b0;
            shot_accept  <= 1'b0;
            game_over    <= 1'b0;
            winner       <= 2'b00;
        end else begin
            shot_accept <= 1'b0;
            if (new_game) begin
                // new_game wins over any shot arriving in the same cycle.
                state_reg    <= PLAY;
                lock_cnt_reg <= '0;
                p1_score     <= 2'd0;
                p2_score     <= 2'd0;
                turn         <= 1'b0;
                game_over    <= 1'b0;
                winner       <= 2'b00;
            end else begin
                case (state_reg)
                    PLAY: begin
                        if (shot_valid) begin
                            shot_accept <= 1'b1;
                            if (turn) begin
                                p2_score <= scored_next;
                            end else begin
                                p1_score <= scored_next;
                            end
                            if (wins) begin
                                // The turn stays with the winner, so the
                                // display shows who made the winning hit.
                                state_reg <= OVER;
                                game_over <= 1'b1;
                                winner    <= turn ? 2'b10 : 2'b01;
                            end else begin
                                if (!keep_turn) begin
                                    turn <= ~turn;
                                end
                                if (LOCKOUT_CYCLES > 0) begin
                                    state_reg    <= LOCKOUT;
                                    lock_cnt_reg <= LOCK_LOAD;
                                end
                            end
                        end
                    end
                    LOCKOUT: begin
                        // The counter is loaded with LOCKOUT_CYCLES, so the
                        // next accepted shot is LOCKOUT_CYCLES+1 cycles after
                        // the previous one. The counter is clamped at 0.
                        if (lock_cnt_reg <= LOCK_ONE) begin
                            lock_cnt_reg <= '0;
                            state_reg    <= PLAY;
                        end else begin
                            lock_cnt_reg <= lock_cnt_reg - LOCK_ONE;
                        end
                    end
                    default: begin
                        // IDLE and OVER: ignore shots and hold all results.
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_score_keeper.sv
// -----------------------------------------------------------------------------
// tb_score_keeper
//
// Drives two score_keeper instances with the same stimulus:
//   dut0: WIN_SCORE=3, LOCKOUT_CYCLES=4
//   dut1: WIN_SCORE=1, LOCKOUT_CYCLES=0
//
// A reference model computes the expected results. It works from the game
// rules: cycle-number arithmetic for the lockout, and plain score counting.
// Each accepted shot pushes the expected post-shot snapshot into a
// per-instance queue. A negedge monitor compares every cycle's outputs. It
// also pops and checks a queue entry whenever a DUT raises shot_accept.
// -----------------------------------------------------------------------------
module tb_score_keeper;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, new_game, shot_valid, shot_hit;
    logic [1:0] p1_s [2];
    logic [1:0] p2_s [2];
    logic [1:0] win_s [2];
    logic       turn_s [2];
    logic       acc_s [2];
    logic       over_s [2];

    score_keeper #(.WIN_SCORE(3), .LOCKOUT_CYCLES(4)) dut0 (
        .clk(clk), .rst(rst), .new_game(new_game), .shot_valid(shot_valid),
        .shot_hit(shot_hit), .p1_score(p1_s[0]), .p2_score(p2_s[0]),
        .turn(turn_s[0]), .shot_accept(acc_s[0]), .game_over(over_s[0]),
        .winner(win_s[0])
    );

    score_keeper #(.WIN_SCORE(1), .LOCKOUT_CYCLES(0)) dut1 (
        .clk(clk), .rst(rst), .new_game(new_game), .shot_valid(shot_valid),
        .shot_hit(shot_hit), .p1_score(p1_s[1]), .p2_score(p2_s[1]),
        .turn(turn_s[1]), .shot_accept(acc_s[1]), .game_over(over_s[1]),
        .winner(win_s[1])
    );

    localparam int W_P [2] = '{3, 1};
    localparam int L_P [2] = '{4, 0};
`ifdef HIT_STREAK_EN
    localparam bit STREAK = 1'b1;
`else
    localparam bit STREAK = 1'b0;
`endif

    typedef struct packed {
        logic [1:0] p1;
        logic [1:0] p2;
        logic       turn;
        logic       over;
        logic [1:0] winner;
    } snap_t;

    snap_t exp_q0 [$];
    snap_t exp_q1 [$];

    // Model state
    snap_t cur [2];
    bit    cur_acc [2];
    bit    m_active [2];
    int    last_acc [2];
    int    cyc;
    bit    mon_en;

    int tests;
    int fails;

    // Decide the next expected outputs of one instance, given this cycle's
    // inputs. The result takes effect at the next clock edge.
    task automatic model_next(input int i, input bit r, input bit ng,
                              input bit sv, input bit sh,
                              output snap_t n, output bit a);
        int s;
        n = cur[i];
        a = 1'b0;
        if (r) begin
            n = '0;
            m_active[i] = 1'b0;
            last_acc[i] = -1000;
        end else if (ng) begin
            n = '0;
            m_active[i] = 1'b1;
            last_acc[i] = -1000;
        end else if (sv && m_active[i] && !n.over && (cyc - last_acc[i] > L_P[i])) begin
            a = 1'b1;
            last_acc[i] = cyc;
            s = n.turn ? int'(n.p2) : int'(n.p1);
            if (sh && s < 3) s = s + 1;
            if (n.turn) n.p2 = 2'(s); else n.p1 = 2'(s);
            if (sh && s == W_P[i]) begin
                n.over   = 1'b1;
                n.winner = n.turn ? 2'b10 : 2'b01;
            end else if (!(STREAK && sh)) begin
                n.turn = !n.turn;
            end
        end
    endtask

    task automatic step(input bit r, input bit ng, input bit sv, input bit sh);
        snap_t n [2];
        bit    a [2];
        rst = r; new_game = ng; shot_valid = sv; shot_hit = sh;
        for (int i = 0; i < 2; i++) begin
            model_next(i, r, ng, sv, sh, n[i], a[i]);
        end
        if (a[0]) exp_q0.push_back(n[0]);
        if (a[1]) exp_q1.push_back(n[1]);
        cyc = cyc + 1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            cur[i]     = n[i];
            cur_acc[i] = a[i];
        end
        mon_en = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic shot(input bit h);
        step(1'b0, 1'b0, 1'b1, h);
    endtask

    // Checks one instance in the current cycle.
    task automatic check_inst(input int i);
        snap_t act;
        snap_t exp_s;
        bit    have;
        act.p1     = p1_s[i];
        act.p2     = p2_s[i];
        act.turn   = turn_s[i];
        act.over   = over_s[i];
        act.winner = win_s[i];

        tests++;
        if (acc_s[i] !== cur_acc[i]) begin
            fails++;
            $display("[TB] FAIL dut%0d accept cyc=%0d got=%b want=%b", i, cyc, acc_s[i], cur_acc[i]);
        end
        tests++;
        if (act !== cur[i]) begin
            fails++;
            $display("[TB] FAIL dut%0d state cyc=%0d got p1=%0d p2=%0d turn=%b over=%b win=%b want p1=%0d p2=%0d turn=%b over=%b win=%b",
                     i, cyc, act.p1, act.p2, act.turn, act.over, act.winner,
                     cur[i].p1, cur[i].p2, cur[i].turn, cur[i].over, cur[i].winner);
        end

        if (acc_s[i] === 1'b1) begin
            have  = 1'b0;
            exp_s = '0;
            if (i == 0 && exp_q0.size() > 0) begin
                exp_s = exp_q0.pop_front(); have = 1'b1;
            end else if (i == 1 && exp_q1.size() > 0) begin
                exp_s = exp_q1.pop_front(); have = 1'b1;
            end
            tests++;
            if (!have) begin
                fails++;
                $display("[TB] FAIL dut%0d shot cyc=%0d got unexpected shot_accept want none", i, cyc);
            end else if (act !== exp_s) begin
                fails++;
                $display("[TB] FAIL dut%0d shot cyc=%0d got p1=%0d p2=%0d turn=%b over=%b win=%b want p1=%0d p2=%0d turn=%b over=%b win=%b",
                         i, cyc, act.p1, act.p2, act.turn, act.over, act.winner,
                         exp_s.p1, exp_s.p2, exp_s.turn, exp_s.over, exp_s.winner);
            end else begin
                $display("[TB] dut%0d shot cyc=%0d p1=%0d p2=%0d turn=%b over=%b win=%b",
                         i, cyc, act.p1, act.p2, act.turn, act.over, act.winner);
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            check_inst(0);
            check_inst(1);
        end
    end

    initial begin
        tests  = 0;
        fails  = 0;
        cyc    = 0;
        mon_en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cur[i]      = '0;
            cur_acc[i]  = 1'b0;
            m_active[i] = 1'b0;
            last_acc[i] = -1000;
        end
        rst = 1'b1; new_game = 1'b0; shot_valid = 1'b0; shot_hit = 1'b0;

        // Reset, then shots while idle must be ignored.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        shot(1'b1); idle(2); shot(1'b1); idle(2);

        // Regular game: hit, miss, hit, miss, hit spaced six cycles apart.
        step(1'b0, 1'b1, 1'b0, 1'b0);
        shot(1'b1); idle(5); shot(1'b0); idle(5); shot(1'b1); idle(5);
        shot(1'b0); idle(5); shot(1'b1); idle(5);

        // Lockout window: shots at t, t+2, t+4, t+5.
        step(1'b0, 1'b1, 1'b0, 1'b0);
        shot(1'b0); idle(1); shot(1'b0); idle(1); shot(1'b0); shot(1'b0); idle(6);

        // Play until the game is over, shoot while over, then new_game
        // together with a shot, then a normal shot.
        step(1'b0, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 6; k++) begin
            shot(1'b1); idle(5);
        end
        shot(1'b1); idle(2);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        idle(5); shot(1'b1); idle(5);

        // Reset during lockout, then a shot that must be ignored.
        step(1'b0, 1'b1, 1'b0, 1'b0);
        shot(1'b1); idle(5); shot(1'b1); idle(5); shot(1'b1); idle(1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        shot(1'b1); idle(2);

        // Randomized play.
        step(1'b0, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 1500; k++) begin
            step(($urandom % 250) == 0, ($urandom % 40) == 0,
                 ($urandom % 3) == 0, ($urandom % 2) == 1);
        end
        idle(3);

        tests++;
        if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
            fails++;
            $display("[TB] FAIL drain got q0=%0d q1=%0d pending want 0", exp_q0.size(), exp_q1.size());
        end

        @(negedge clk);
        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
